// File: rtl/pipe_pkg.sv
// pipe_pkg: shared MUL/DIV sequencer state type and default unit latencies.
package pipe_pkg;
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;
   localparam int MUL_LAT_DEF = 4;
   localparam int DIV_LAT_DEF = 32;
endpackage

// File: rtl/md_latency_ctr.sv
// md_latency_ctr: loadable down-counter with zero flag; holds at zero instead of wrapping.
module md_latency_ctr #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] loadVal,
   output logic [CNT_W-1:0] count,
   output logic             zero
);
   assign zero = (count == '0);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else if (load) count <= loadVal;
      else if (dec && !zero) count <= count - 1'b1;
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline stall/flush merge plus MUL/DIV latency sequencer.
// Define HAZARD_PERF_EN to add saturating stall / md-hazard cycle counters.
module hazard_sequencer
   import pipe_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF,
   parameter int CNT_W   = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch_stall,
   input  logic        lw_stall,
   input  logic        md_op_d,
   input  logic        md_div_d,
   input  logic        hilo_use_d,
   input  logic        pc_redirect,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushD,
   output logic        FlushE,
   output logic        md_start,
   output logic        md_busy,
   output logic        md_done
`ifdef HAZARD_PERF_EN
  ,output logic [31:0] perf_stall_cyc,
   output logic [31:0] perf_md_cyc
`endif
);
   md_state_t state, nextState;
   logic ctrZero, mdHz, stall;
   logic [CNT_W-1:0] ctrVal;
   assign md_busy  = (state == MUL) || (state == DIV);
   assign md_done  = (state == DONE);
   assign mdHz     = (md_op_d || hilo_use_d) && md_busy;
   // Inputs are gated so every output reads 0 while reset is held.
   assign stall    = rst_n && (branch_stall || lw_stall || mdHz);
   assign StallF   = stall;
   assign StallD   = stall;
   assign FlushE   = stall;
   assign FlushD   = rst_n && pc_redirect && !stall;
   assign md_start = rst_n && md_op_d && !stall && !md_busy;
   // A start is only possible from IDLE or DONE, so it takes priority.
   always_comb
      nextState = md_start ? (md_div_d ? DIV : MUL) :
                  md_busy  ? (ctrZero ? DONE : state) : IDLE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nextState;
   md_latency_ctr #(.CNT_W(CNT_W)) uCtr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (md_start),
      .dec     (md_busy),
      .loadVal (md_div_d ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1)),
      .count   (ctrVal),
      .zero    (ctrZero)
   );
`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         perf_stall_cyc <= '0;
         perf_md_cyc    <= '0;
      end else begin
         if (stall && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 1'b1;
         if (mdHz && perf_md_cyc != '1) perf_md_cyc <= perf_md_cyc + 1'b1;
      end
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed plus random stimulus against a cycle-level reference model.
module tb_hazard_sequencer;
   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 32;
   logic clk = 0, rst_n = 0;
   logic branch_stall = 0, lw_stall = 0, md_op_d = 0, md_div_d = 0, hilo_use_d = 0, pc_redirect = 0;
   logic StallF, StallD, FlushD, FlushE, md_start, md_busy, md_done;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cyc, perf_md_cyc;
`endif
   int errors = 0, checks = 0;
   int rem = 0, stallCnt = 0, mdCnt = 0;
   bit doneNow = 0;
   always #5 clk = ~clk;
   hazard_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .branch_stall(branch_stall), .lw_stall(lw_stall),
      .md_op_d(md_op_d), .md_div_d(md_div_d), .hilo_use_d(hilo_use_d), .pc_redirect(pc_redirect),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .md_start(md_start), .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_PERF_EN
     ,.perf_stall_cyc(perf_stall_cyc), .perf_md_cyc(perf_md_cyc)
`endif
   );
   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask
   // One pipeline cycle: drive at negedge, check settled outputs, advance model at posedge.
   task automatic runCycle(input logic rn, bs, lw, op, dv, hu, pr);
      bit eBusy, eDone, eHz, eStall, eStart, eFlushD;
      @(negedge clk);
      rst_n = rn; branch_stall = bs; lw_stall = lw; md_op_d = op;
      md_div_d = dv; hilo_use_d = hu; pc_redirect = pr;
      if (!rn) begin rem = 0; doneNow = 0; stallCnt = 0; mdCnt = 0; end
      #1;
      eBusy   = rn && rem > 0;
      eDone   = rn && doneNow;
      eHz     = (op || hu) && eBusy;
      eStall  = rn && (bs || lw || eHz);
      eStart  = rn && op && !eStall && !eBusy;
      eFlushD = rn && pr && !eStall;
      checkVal("StallF", StallF, eStall);
      checkVal("StallD", StallD, eStall);
      checkVal("FlushE", FlushE, eStall);
      checkVal("FlushD", FlushD, eFlushD);
      checkVal("md_start", md_start, eStart);
      checkVal("md_busy", md_busy, eBusy);
      checkVal("md_done", md_done, eDone);
`ifdef HAZARD_PERF_EN
      checkVal("perf_stall_cyc", perf_stall_cyc, stallCnt);
      checkVal("perf_md_cyc", perf_md_cyc, mdCnt);
`endif
      @(posedge clk);
      if (rn) begin
         stallCnt += int'(eStall);
         mdCnt += int'(eHz);
         if (eStart) begin rem = dv ? DIV_LAT : MUL_LAT; doneNow = 0; end
         else if (rem > 0) begin rem--; doneNow = (rem == 0); end
         else doneNow = 0;
      end
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) runCycle(1, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      runCycle(0, 0, 0, 0, 0, 0, 0);
      runCycle(0, 1, 1, 1, 1, 1, 1);
      idle(2);
      runCycle(1, 1, 0, 0, 0, 0, 1);
      runCycle(1, 1, 0, 0, 0, 0, 1);
      runCycle(1, 0, 0, 0, 0, 0, 1);
      runCycle(1, 0, 0, 1, 0, 0, 0);
      idle(6);
      runCycle(1, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) runCycle(1, 0, 0, 0, 0, 1, 0);
      idle(2);
      for (int i = 0; i < 36; i++) runCycle(1, 0, 0, 1, 1, 0, 0);
      idle(36);
      runCycle(1, 0, 0, 1, 1, 0, 0);
      idle(9);
      runCycle(0, 0, 0, 0, 0, 0, 0);
      runCycle(0, 0, 0, 1, 1, 1, 1);
      idle(40);
      for (int i = 0; i < 3; i++) runCycle(1, 0, 1, 0, 0, 0, 0);
      runCycle(1, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) runCycle(1, 0, 0, 0, 0, 1, 0);
      idle(2);
      for (int i = 0; i < 3000; i++)
         runCycle($urandom_range(0, 299) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
